// File: rtl/augment_pingpong_buffer.sv
// Double-buffered frame store: a raster producer fills one bank while a consumer
// random-accesses the last completed frame in the other bank by (x, y) coordinate.
module augment_pingpong_buffer #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PIX_W = 8,
  localparam int N  = IMG_W * IMG_H,
  localparam int AW = $clog2(N),
  localparam int XW = $clog2(IMG_W) + 1,
  localparam int YW = $clog2(IMG_H) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             rd_frame_avail,
  input  logic             rd_en,
  input  logic [XW-1:0]    rd_x,
  input  logic [YW-1:0]    rd_y,
  input  logic             rd_flip,
  output logic [PIX_W-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_release,
  output logic [15:0]      frame_count
);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  localparam logic [XW-1:0] LP_W_X   = XW'(IMG_W);
  localparam logic [XW-1:0] LP_XMAX  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] LP_H_Y   = YW'(IMG_H);
  localparam logic [AW-1:0] LP_W_A   = AW'(IMG_W);
  localparam logic [AW-1:0] LP_LAST  = AW'(N - 1);

  // Handshake: a pixel moves when in_valid & in_ready at a rising edge; a read
  // request is taken when rd_en & rd_frame_avail, answered one cycle later on
  // rd_valid/rd_data; rd_release retires the readable bank when one exists.

  // ---------------------------------------------------------------- state
  bank_state_e r_bank_state [2];
  bank_state_e w_bank_state_nxt [2];
  logic        r_wr_sel, w_wr_sel_nxt;
  logic        r_rd_sel, w_rd_sel_nxt;
  logic [AW-1:0] r_wr_cnt, w_wr_cnt_nxt;
  logic [15:0]   r_frame_count, w_frame_count_nxt;
  logic          r_rd_valid;
  logic [PIX_W-1:0] r_rd_data;

  logic [PIX_W-1:0] r_mem0 [N];
  logic [PIX_W-1:0] r_mem1 [N];

  // ---------------------------------------------------------------- handshakes
  logic w_accept;
  logic w_last_pix;
  logic w_release;
  logic w_rd_accept;

  assign in_ready       = (r_bank_state[r_wr_sel] == BANK_EMPTY) ||
                          (r_bank_state[r_wr_sel] == BANK_FILLING);
  assign rd_frame_avail = (r_bank_state[r_rd_sel] == BANK_FULL);
  assign w_accept       = in_valid & in_ready;
  assign w_last_pix     = (r_wr_cnt == LP_LAST);
  assign w_release      = rd_release & rd_frame_avail;
  assign w_rd_accept    = rd_en & rd_frame_avail;

  // ---------------------------------------------------------------- read address
  logic          w_in_range;
  logic [XW-1:0] w_col;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] w_addr_safe;
  logic [PIX_W-1:0] w_mem_word;

  assign w_in_range  = (rd_x < LP_W_X) && (rd_y < LP_H_Y);
  assign w_col       = rd_flip ? (LP_XMAX - rd_x) : rd_x;
  assign w_addr      = AW'(rd_y) * LP_W_A + AW'(w_col);
  // Out-of-range coordinates would index past the array; steer them to word 0.
  assign w_addr_safe = w_in_range ? w_addr : '0;
  assign w_mem_word  = r_rd_sel ? r_mem1[w_addr_safe] : r_mem0[w_addr_safe];

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_bank_state_nxt[0] = r_bank_state[0];
    w_bank_state_nxt[1] = r_bank_state[1];
    w_wr_sel_nxt        = r_wr_sel;
    w_rd_sel_nxt        = r_rd_sel;
    w_wr_cnt_nxt        = r_wr_cnt;
    w_frame_count_nxt   = r_frame_count;

    if (w_accept) begin
      if (w_last_pix) begin
        w_wr_cnt_nxt = '0;
        w_wr_sel_nxt = ~r_wr_sel;
      end else begin
        w_wr_cnt_nxt = r_wr_cnt + 1'b1;
      end
    end

    if (w_release) begin
      w_rd_sel_nxt      = ~r_rd_sel;
      w_frame_count_nxt = r_frame_count + 16'd1;
    end

    // The write bank is never FULL and the release bank always is, so the two
    // updates below never target the same bank in one cycle.
    for (int b = 0; b < 2; b++) begin
      if (w_accept && (r_wr_sel == b[0])) begin
        w_bank_state_nxt[b] = w_last_pix ? BANK_FULL : BANK_FILLING;
      end
      if (w_release && (r_rd_sel == b[0])) begin
        w_bank_state_nxt[b] = BANK_EMPTY;
      end
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bank_state[0] <= BANK_EMPTY;
      r_bank_state[1] <= BANK_EMPTY;
      r_wr_sel        <= 1'b0;
      r_rd_sel        <= 1'b0;
      r_wr_cnt        <= '0;
      r_frame_count   <= '0;
      r_rd_valid      <= 1'b0;
      r_rd_data       <= '0;
    end else if (restart) begin
      r_bank_state[0] <= BANK_EMPTY;
      r_bank_state[1] <= BANK_EMPTY;
      r_wr_sel        <= 1'b0;
      r_rd_sel        <= 1'b0;
      r_wr_cnt        <= '0;
      r_frame_count   <= '0;
      r_rd_valid      <= 1'b0;
    end else begin
      r_bank_state[0] <= w_bank_state_nxt[0];
      r_bank_state[1] <= w_bank_state_nxt[1];
      r_wr_sel        <= w_wr_sel_nxt;
      r_rd_sel        <= w_rd_sel_nxt;
      r_wr_cnt        <= w_wr_cnt_nxt;
      r_frame_count   <= w_frame_count_nxt;
      r_rd_valid      <= w_rd_accept;
      // A release in the same cycle still reads from the bank being released.
      if (w_rd_accept) begin
        r_rd_data <= w_in_range ? w_mem_word : '0;
      end
    end
  end

  // Memory contents are never cleared; only the control state is.
  always_ff @(posedge clk) begin
    if (w_accept && !restart) begin
      if (r_wr_sel) begin
        r_mem1[r_wr_cnt] <= in_pixel;
      end else begin
        r_mem0[r_wr_cnt] <= in_pixel;
      end
    end
  end

  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_augment_pingpong_buffer.sv
// Directed bench for augment_pingpong_buffer on a 4x3 image: reads are scored
// through an expected queue drained by a monitor on the falling clock edge.
module tb_augment_pingpong_buffer;

  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int PIX_W = 8;
  localparam int XW    = $clog2(IMG_W) + 1;
  localparam int YW    = $clog2(IMG_H) + 1;

  logic             clk;
  logic             reset;
  logic             restart;
  logic [PIX_W-1:0] in_pixel;
  logic             in_valid;
  logic             in_ready;
  logic             rd_frame_avail;
  logic             rd_en;
  logic [XW-1:0]    rd_x;
  logic [YW-1:0]    rd_y;
  logic             rd_flip;
  logic [PIX_W-1:0] rd_data;
  logic             rd_valid;
  logic             rd_release;
  logic [15:0]      frame_count;

  logic [PIX_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  augment_pingpong_buffer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
    .rd_frame_avail(rd_frame_avail),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_flip(rd_flip),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_release(rd_release), .frame_count(frame_count)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_pixel(input logic [PIX_W-1:0] p);
    in_pixel = p;
    in_valid = 1'b1;
    for (int t = 0; t < 100 && !in_ready; t++) step();
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL in_ready_timeout: got 0 expected 1 for pixel %0d", p);
    end
    step();
  endtask

  task automatic send_frame(input logic [PIX_W-1:0] base, input int count);
    for (int i = 0; i < count; i++) push_pixel(base + PIX_W'(i));
    in_valid = 1'b0;
  endtask

  task automatic rd(input int x, input int y, input logic flip, input logic [PIX_W-1:0] exp);
    rd_en   = 1'b1;
    rd_x    = XW'(x);
    rd_y    = YW'(y);
    rd_flip = flip;
    exp_q.push_back(exp);
    step();
    rd_en   = 1'b0;
  endtask

  task automatic rd_unscored(input int x, input int y);
    rd_en   = 1'b1;
    rd_x    = XW'(x);
    rd_y    = YW'(y);
    rd_flip = 1'b0;
    step();
    rd_en   = 1'b0;
  endtask

  task automatic release_frame();
    rd_release = 1'b1;
    step();
    rd_release = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  // ---------------------------------------------------------------- scoreboard monitor
  always @(negedge clk) begin
    if (rd_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_rd_valid: got rd_valid=1 data=%0d expected rd_valid=0", rd_data);
      end else begin
        logic [PIX_W-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_err++;
          $display("FAIL rd_data: got %0d expected %0d", rd_data, e);
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset = 1'b1; restart = 1'b0; in_pixel = '0; in_valid = 1'b0;
    rd_en = 1'b0; rd_x = '0; rd_y = '0; rd_flip = 1'b0; rd_release = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_avail", 32'(rd_frame_avail), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    check("reset_frame_count", 32'(frame_count), 32'd0);

    // Single frame, plain / flipped / out-of-range reads.
    send_frame(8'd0, 12);
    check("avail_after_frame", 32'(rd_frame_avail), 32'd1);
    rd(0, 0, 1'b0, 8'd0);
    rd(3, 2, 1'b0, 8'd11);
    rd(1, 1, 1'b0, 8'd5);
    rd(0, 1, 1'b1, 8'd7);
    rd(3, 0, 1'b1, 8'd0);
    rd(4, 0, 1'b0, 8'd0);
    rd(0, 3, 1'b0, 8'd0);
    step();
    release_frame();
    check("avail_after_release", 32'(rd_frame_avail), 32'd0);
    check("count_after_release", 32'(frame_count), 32'd1);
    rd_unscored(1, 1);
    step();

    // Two frames without release: producer is held off until A is released.
    do_restart();
    check("restart_count", 32'(frame_count), 32'd0);
    send_frame(8'd0, 12);
    send_frame(8'd100, 12);
    check("in_ready_both_full", 32'(in_ready), 32'd0);
    in_pixel = 8'd200;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("frame_c_held", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    rd(0, 0, 1'b0, 8'd0);
    rd(3, 2, 1'b0, 8'd11);
    release_frame();
    check("in_ready_after_release", 32'(in_ready), 32'd1);
    check("count_ab", 32'(frame_count), 32'd1);
    check("avail_b", 32'(rd_frame_avail), 32'd1);
    rd(0, 0, 1'b0, 8'd100);
    rd(2, 1, 1'b0, 8'd106);
    rd(1, 2, 1'b1, 8'd110);

    // Last pixel of B coincides with release of A.
    do_restart();
    send_frame(8'd0, 12);
    send_frame(8'd100, 11);
    in_pixel   = 8'd111;
    in_valid   = 1'b1;
    rd_release = 1'b1;
    check("in_ready_last_b", 32'(in_ready), 32'd1);
    step();
    in_valid   = 1'b0;
    rd_release = 1'b0;
    check("avail_coincident", 32'(rd_frame_avail), 32'd1);
    check("count_coincident", 32'(frame_count), 32'd1);
    check("in_ready_coincident", 32'(in_ready), 32'd1);
    rd(3, 2, 1'b0, 8'd111);
    rd(0, 0, 1'b0, 8'd100);
    step();

    // Asynchronous reset mid-frame with a read in flight.
    send_frame(8'd50, 5);
    rd_unscored(2, 2);
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    check("midreset_avail", 32'(rd_frame_avail), 32'd0);
    check("midreset_count", 32'(frame_count), 32'd0);
    check("midreset_rd_data", 32'(rd_data), 32'd0);
    send_frame(8'd20, 12);
    check("midreset_frame_avail", 32'(rd_frame_avail), 32'd1);
    rd(1, 2, 1'b0, 8'd29);
    rd(3, 0, 1'b1, 8'd20);
    step();

    // Same sequence using restart, with a read requested on the restart edge.
    send_frame(8'd60, 5);
    rd_en = 1'b1; rd_x = '0; rd_y = '0; rd_flip = 1'b0;
    do_restart();
    rd_en = 1'b0;
    check("restart_rd_valid", 32'(rd_valid), 32'd0);
    check("restart_in_ready", 32'(in_ready), 32'd1);
    check("restart_avail", 32'(rd_frame_avail), 32'd0);
    check("restart_count2", 32'(frame_count), 32'd0);
    send_frame(8'd40, 12);
    check("restart_frame_avail", 32'(rd_frame_avail), 32'd1);
    rd(2, 2, 1'b0, 8'd50);
    rd(0, 0, 1'b0, 8'd40);
    step(); step();

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/augment_pingpong_buffer.md
# augment_pingpong_buffer

Parametrised double-buffered frame store between two augmentation stages, replacing the single internal image BRAM. Accepts a raster pixel stream from a producer stage (e.g. rotation) into one bank while a consumer stage (e.g. resized crop) random-accesses the previously completed frame in the other bank by (x, y) coordinate. Adds producer backpressure, out-of-range zero padding and an optional horizontal-flip read mode.

## Interface
- IMG_W, 28, image width in pixels (≥2)
- IMG_H, 28, image height in pixels (≥2)
- PIX_W, 8, pixel width in bits
- N (derived), IMG_W*IMG_H, pixels per frame; AW = clog2(N); XW = clog2(IMG_W)+1; YW = clog2(IMG_H)+1
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-high
- restart  in  1  synchronous clear of control state (memory contents untouched)
- in_pixel  in  PIX_W  producer pixel, raster order
- in_valid  in  1  producer pixel valid
- in_ready  out  1  buffer can accept a pixel this cycle
- rd_frame_avail  out  1  a complete frame is readable
- rd_en  in  1  read request
- rd_x  in  XW  column, unsigned
- rd_y  in  YW  row, unsigned
- rd_flip  in  1  1 = read column IMG_W-1-rd_x
- rd_data  out  PIX_W  read data
- rd_valid  out  1  rd_data valid
- rd_release  in  1  consumer finished with current frame (pulse)
- frame_count  out  16  frames released since reset/restart, wraps

## Operation
- Two banks of N×PIX_W, each with state EMPTY, FILLING, FULL. Pointers wr_sel, rd_sel (1 bit each).
- in_ready = bank[wr_sel] ∈ {EMPTY, FILLING}, combinational from registered state.
- Accept on in_valid & in_ready: write in_pixel at bank[wr_sel][wr_cnt]; wr_cnt++; bank EMPTY→FILLING on first pixel.
- On accepting pixel N-1: bank[wr_sel]→FULL, wr_cnt←0, wr_sel toggles.
- rd_frame_avail = bank[rd_sel]==FULL.
- Read accepted when rd_en & rd_frame_avail; rd_en ignored otherwise (rd_valid stays 0).
- Address: col = rd_flip ? IMG_W-1-rd_x : rd_x; addr = rd_y*IMG_W + col, AW bits.
- Out-of-range (rd_x ≥ IMG_W or rd_y ≥ IMG_H): no memory read meaningfully used, rd_data = 0, rd_valid = 1.
- rd_release while rd_frame_avail: bank[rd_sel]→EMPTY, rd_sel toggles, frame_count++. Ignored when !rd_frame_avail.
- Same-cycle last-write and release hit different banks by construction; both take effect. Release of bank B and acceptance into bank B cannot coincide.
- Read accepted in the same cycle as rd_release: data still returned from the released bank.
- restart: banks EMPTY, wr_sel=rd_sel=0, wr_cnt=0, frame_count=0, rd_valid=0; a partially written frame is discarded.

## Timing
- Reset values: in_ready=1, rd_frame_avail=0, rd_valid=0, rd_data=0, frame_count=0; internal states EMPTY, pointers 0, wr_cnt 0.
- Write: pixel stored on the accepting edge; rd_frame_avail rises the cycle after the edge accepting pixel N-1.
- Read latency 1: request at edge t → rd_data/rd_valid valid after edge t+1; back-to-back reads, one per cycle.
- rd_valid deasserts the cycle after the last accepted request.
- in_ready drops the cycle after the second frame completes while first is unreleased; rises the cycle after rd_release.
- Reset asserted mid-frame: all state returns to reset values immediately; no pending rd_valid survives.
- frame_count wraps 0xFFFF→0.

## Test plan
- IMG_W=4, IMG_H=3: stream pixels 0..11 continuously → rd_frame_avail=1 one cycle after pixel 11; reads (0,0),(3,2),(1,1) return 0, 11, 5 with rd_valid one cycle after each rd_en.
- rd_flip=1, read (0,1) → 7; read (3,0) → 0.
- Read (4,0) and (0,3) → rd_data 0, rd_valid 1; rd_en with rd_frame_avail=0 → rd_valid 0.
- Stream frames A (0..11) and B (100..111) without release → in_ready=0 after B; frame C held off; rd_release → reads return B values, in_ready=1 next cycle, frame_count=1.
- Last pixel of frame B and rd_release of frame A in the same cycle → rd_frame_avail stays 1, rd_sel points to B, reads return B.
- Assert reset after 5 pixels of a frame → in_ready=1, rd_frame_avail=0, frame_count=0; new 12-pixel frame reads back correctly; repeat with restart for identical result.
